// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: state encoding and
// the default access timeout.
package mem_stage_pkg;

    // Controller states of the data-memory handshake.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // Cycles spent in REQ waiting for an acknowledge before giving up.
    localparam int TIMEOUT_DEFAULT = 15;

    // Width of the wait counter; holds any timeout up to 255.
    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register bank. A load captures a complete new slot;
// a bubble kills the slot (valid and register write cleared) while the
// remaining fields keep their previous contents.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        bubble_en,
    input  logic        ld_valid,
    input  logic        ld_mem_to_reg,
    input  logic        ld_reg_write,
    input  logic [31:0] ld_alu_result,
    input  logic [31:0] ld_rdata,
    input  logic [4:0]  ld_dest_reg,
    output logic        valid,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [31:0] alu_result,
    output logic [31:0] rdata,
    output logic [4:0]  dest_reg
);

    logic        valid_q, valid_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  dest_reg_q, dest_reg_d;

    // Select between hold, full load and bubble for the next slot contents.
    always_comb begin
        valid_d      = valid_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        alu_result_d = alu_result_q;
        rdata_d      = rdata_q;
        dest_reg_d   = dest_reg_q;
        if (load_en) begin
            valid_d      = ld_valid;
            mem_to_reg_d = ld_mem_to_reg;
            reg_write_d  = ld_reg_write;
            alu_result_d = ld_alu_result;
            rdata_d      = ld_rdata;
            dest_reg_d   = ld_dest_reg;
        end else if (bubble_en) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end
    end

    // Register the slot; reset empties it completely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_result_q <= 32'd0;
            rdata_q      <= 32'd0;
            dest_reg_q   <= 5'd0;
        end else begin
            valid_q      <= valid_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            alu_result_q <= alu_result_d;
            rdata_q      <= rdata_d;
            dest_reg_q   <= dest_reg_d;
        end
    end

    assign valid      = valid_q;
    assign mem_to_reg = mem_to_reg_q;
    assign reg_write  = reg_write_q;
    assign alu_result = alu_result_q;
    assign rdata      = rdata_q;
    assign dest_reg   = dest_reg_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. Non-memory instructions pass straight into MEM/WB
// in one cycle. Loads and stores latch their request, hold the pipeline
// with Stall and run a req/ack handshake that is abandoned after TIMEOUT
// REQ cycles; an abandoned access completes harmlessly (no register
// write) and raises the sticky Mem_err flag.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] Store_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic [4:0]  DestReg_in,
    output logic        Dmem_req,
    output logic        Dmem_we,
    output logic [31:0] Dmem_addr,
    output logic [31:0] Dmem_wdata,
    input  logic        Dmem_ack,
    input  logic [31:0] Dmem_rdata,
    output logic        Stall,
    output logic        valid_out,
    output logic        MemToReg,
    output logic        RegWrite_out,
    output logic [31:0] ALU_result,
    output logic [31:0] MemRead_data,
    output logic [4:0]  DestReg_out,
    output logic        Mem_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               reg_write_q, reg_write_d;
    logic [4:0]         dest_q, dest_d;
    logic               mem_err_q, mem_err_d;

    logic               memop;
    logic               stall_c;
    logic               wb_load;
    logic               wb_bubble;
    logic               wb_mem_to_reg;
    logic               wb_reg_write;
    logic [31:0]        wb_alu_result;
    logic [31:0]        wb_rdata;
    logic [4:0]         wb_dest;

    assign memop = valid_in & (MemRead | MemWrite);

    // Next-state logic: launch accesses, wait for ack or timeout, and steer the MEM/WB bank.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        mem_to_reg_d  = mem_to_reg_q;
        reg_write_d   = reg_write_q;
        dest_d        = dest_q;
        mem_err_d     = mem_err_q;
        stall_c       = 1'b0;
        wb_load       = 1'b0;
        wb_bubble     = 1'b0;
        wb_mem_to_reg = MemToReg_in;
        wb_reg_write  = RegWrite_in;
        wb_alu_result = ALU_result_in;
        wb_rdata      = 32'd0;
        wb_dest       = DestReg_in;
        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    // A store wins when both read and write are requested.
                    stall_c      = 1'b1;
                    wb_bubble    = 1'b1;
                    addr_d       = ALU_result_in;
                    wdata_d      = Store_data;
                    we_d         = MemWrite;
                    mem_to_reg_d = MemToReg_in;
                    reg_write_d  = RegWrite_in;
                    dest_d       = DestReg_in;
                    wait_cnt_d   = '0;
                    state_d      = REQ;
                end else if (valid_in) begin
                    wb_load = 1'b1;
                end else begin
                    wb_bubble = 1'b1;
                end
            end
            REQ: begin
                wb_mem_to_reg = mem_to_reg_q;
                wb_reg_write  = reg_write_q;
                wb_alu_result = addr_q;
                wb_dest       = dest_q;
                if (Dmem_ack) begin
                    // An ack always beats the timeout, even in the final REQ cycle.
                    wb_load    = 1'b1;
                    wb_rdata   = we_q ? 32'd0 : Dmem_rdata;
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    wb_load      = 1'b1;
                    wb_reg_write = 1'b0;
                    mem_err_d    = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = IDLE;
                end else begin
                    stall_c    = 1'b1;
                    wb_bubble  = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, wait counter, latched request and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            we_q         <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            dest_q       <= 5'd0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            dest_q       <= dest_d;
            mem_err_q    <= mem_err_d;
        end
    end

    // Memory port is driven purely from registered state so it stays stable through the access.
    assign Dmem_req   = (state_q == REQ);
    assign Dmem_we    = (state_q == REQ) & we_q;
    assign Dmem_addr  = addr_q;
    assign Dmem_wdata = wdata_q;

    // Stall is forced low while reset is held, even with a memop waiting upstream.
    assign Stall   = stall_c & rst_n;
    assign Mem_err = mem_err_q;

    mem_wb_reg u_mem_wb_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_en       (wb_load),
        .bubble_en     (wb_bubble),
        .ld_valid      (1'b1),
        .ld_mem_to_reg (wb_mem_to_reg),
        .ld_reg_write  (wb_reg_write),
        .ld_alu_result (wb_alu_result),
        .ld_rdata      (wb_rdata),
        .ld_dest_reg   (wb_dest),
        .valid         (valid_out),
        .mem_to_reg    (MemToReg),
        .reg_write     (RegWrite_out),
        .alu_result    (ALU_result),
        .rdata         (MemRead_data),
        .dest_reg      (DestReg_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB slots are queued when an
// instruction is issued and compared whenever valid_out is seen.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 15;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  dest;
        logic        rw;
        logic        mtr;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] ALU_result_in;
    logic [31:0] Store_data;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg_in;
    logic        RegWrite_in;
    logic [4:0]  DestReg_in;
    logic        Dmem_req;
    logic        Dmem_we;
    logic [31:0] Dmem_addr;
    logic [31:0] Dmem_wdata;
    logic        Dmem_ack;
    logic [31:0] Dmem_rdata;
    logic        Stall;
    logic        valid_out;
    logic        MemToReg;
    logic        RegWrite_out;
    logic [31:0] ALU_result;
    logic [31:0] MemRead_data;
    logic [4:0]  DestReg_out;
    logic        Mem_err;

    int  errors = 0;
    int  checks = 0;
    wb_t sb[$];

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .ALU_result_in (ALU_result_in),
        .Store_data    (Store_data),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemToReg_in   (MemToReg_in),
        .RegWrite_in   (RegWrite_in),
        .DestReg_in    (DestReg_in),
        .Dmem_req      (Dmem_req),
        .Dmem_we       (Dmem_we),
        .Dmem_addr     (Dmem_addr),
        .Dmem_wdata    (Dmem_wdata),
        .Dmem_ack      (Dmem_ack),
        .Dmem_rdata    (Dmem_rdata),
        .Stall         (Stall),
        .valid_out     (valid_out),
        .MemToReg      (MemToReg),
        .RegWrite_out  (RegWrite_out),
        .ALU_result    (ALU_result),
        .MemRead_data  (MemRead_data),
        .DestReg_out   (DestReg_out),
        .Mem_err       (Mem_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic vin, input logic rd, input logic wr,
                                 input logic [31:0] alu, input logic [31:0] sdata,
                                 input logic mtr, input logic rw, input logic [4:0] dest);
        valid_in      = vin;
        MemRead       = rd;
        MemWrite      = wr;
        ALU_result_in = alu;
        Store_data    = sdata;
        MemToReg_in   = mtr;
        RegWrite_in   = rw;
        DestReg_in    = dest;
    endtask

    // Advance one clock and compare any slot the DUT presents against the scoreboard.
    task automatic stepClock();
        wb_t exp;
        @(posedge clk);
        #1;
        if (valid_out) begin
            checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checkOutput("wb_alu_result", ALU_result, exp.alu);
                checkOutput("wb_memread_data", MemRead_data, exp.rdata);
                checkOutput("wb_dest_reg", 32'(DestReg_out), 32'(exp.dest));
                checkOutput("wb_regwrite", 32'(RegWrite_out), 32'(exp.rw));
                checkOutput("wb_memtoreg", 32'(MemToReg), 32'(exp.mtr));
            end
        end
    endtask

    initial begin
        int stallCycles;
        int reqCycles;

        rst_n      = 1'b0;
        Dmem_ack   = 1'b0;
        Dmem_rdata = 32'd0;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        $display("[TB] reset phase");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid_out", 32'(valid_out), 0);
        checkOutput("rst_regwrite", 32'(RegWrite_out), 0);
        checkOutput("rst_memtoreg", 32'(MemToReg), 0);
        checkOutput("rst_alu_result", ALU_result, 0);
        checkOutput("rst_memread_data", MemRead_data, 0);
        checkOutput("rst_dest", 32'(DestReg_out), 0);
        checkOutput("rst_mem_err", 32'(Mem_err), 0);
        checkOutput("rst_stall", 32'(Stall), 0);
        checkOutput("rst_dmem_req", 32'(Dmem_req), 0);
        checkOutput("rst_dmem_we", 32'(Dmem_we), 0);
        #2;
        rst_n = 1'b1;
        stepClock();

        // ALU op passes through in one cycle without stalling.
        $display("[TB] alu op");
        applyStimulus(1, 0, 0, 32'h0000_0010, 32'd0, 0, 1, 5'd3);
        sb.push_back('{alu: 32'h10, rdata: 32'd0, dest: 5'd3, rw: 1'b1, mtr: 1'b0});
        #1;
        checkOutput("alu_stall", 32'(Stall), 0);
        stepClock();
        checkOutput("alu_valid_out", 32'(valid_out), 1);
        applyStimulus(0, 0, 0, 32'hFFFF_FFFF, 32'd0, 0, 1, 5'd31);
        #1;
        checkOutput("bubble_stall", 32'(Stall), 0);
        stepClock();
        checkOutput("bubble_valid_out", 32'(valid_out), 0);
        checkOutput("bubble_regwrite", 32'(RegWrite_out), 0);
        checkOutput("bubble_alu_hold", ALU_result, 32'h10);

        // An acknowledge seen while idle is ignored.
        Dmem_ack   = 1'b1;
        Dmem_rdata = 32'h1111_1111;
        #1;
        checkOutput("idle_ack_req", 32'(Dmem_req), 0);
        stepClock();
        checkOutput("idle_ack_valid", 32'(valid_out), 0);
        Dmem_ack = 1'b0;

        // Load acknowledged in the fourth REQ cycle: stall covers the issue cycle plus three waits.
        $display("[TB] load with wait states");
        applyStimulus(1, 1, 0, 32'h0000_0100, 32'd0, 1, 1, 5'd5);
        #1;
        stallCycles = Stall ? 1 : 0;
        checkOutput("load_idle_no_req", 32'(Dmem_req), 0);
        stepClock();
        for (int n = 1; n <= 4; n++) begin
            if (n == 4) begin
                Dmem_ack   = 1'b1;
                Dmem_rdata = 32'hCAFE_F00D;
                sb.push_back('{alu: 32'h100, rdata: 32'hCAFE_F00D, dest: 5'd5, rw: 1'b1, mtr: 1'b1});
            end else begin
                Dmem_ack   = 1'b0;
                Dmem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            if (Stall) stallCycles++;
            checkOutput("load_req_high", 32'(Dmem_req), 1);
            checkOutput("load_addr", Dmem_addr, 32'h100);
            checkOutput("load_we_low", 32'(Dmem_we), 0);
            checkOutput("load_wait_valid_low", 32'(valid_out), 0);
            stepClock();
        end
        checkOutput("load_stall_cycles", 32'(stallCycles), 4);
        Dmem_ack = 1'b0;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        stepClock();
        checkOutput("load_valid_single_pulse", 32'(valid_out), 0);
        checkOutput("load_req_dropped", 32'(Dmem_req), 0);

        // Store acknowledged in the first REQ cycle; upstream inputs are scrambled to prove latching.
        $display("[TB] store single cycle ack");
        applyStimulus(1, 0, 1, 32'h0000_0200, 32'h1234_5678, 0, 0, 5'd9);
        #1;
        checkOutput("store_issue_stall", 32'(Stall), 1);
        stepClock();
        applyStimulus(1, 0, 0, 32'hAAAA_AAAA, 32'h5555_5555, 1, 1, 5'd1);
        Dmem_ack   = 1'b1;
        Dmem_rdata = 32'hFFFF_FFFF;
        sb.push_back('{alu: 32'h200, rdata: 32'd0, dest: 5'd9, rw: 1'b0, mtr: 1'b0});
        #1;
        checkOutput("store_req", 32'(Dmem_req), 1);
        checkOutput("store_we", 32'(Dmem_we), 1);
        checkOutput("store_addr", Dmem_addr, 32'h200);
        checkOutput("store_wdata", Dmem_wdata, 32'h1234_5678);
        checkOutput("store_ack_stall", 32'(Stall), 0);
        stepClock();
        checkOutput("store_valid_2cyc", 32'(valid_out), 1);
        Dmem_ack = 1'b0;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        stepClock();

        // Read and write together behave as a store.
        $display("[TB] read+write treated as store");
        applyStimulus(1, 1, 1, 32'h0000_0280, 32'hA5A5_A5A5, 1, 1, 5'd10);
        stepClock();
        #1;
        checkOutput("rw_we", 32'(Dmem_we), 1);
        checkOutput("rw_wdata", Dmem_wdata, 32'hA5A5_A5A5);
        stepClock();
        Dmem_ack   = 1'b1;
        Dmem_rdata = 32'h7777_7777;
        sb.push_back('{alu: 32'h280, rdata: 32'd0, dest: 5'd10, rw: 1'b1, mtr: 1'b1});
        stepClock();
        Dmem_ack = 1'b0;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        stepClock();

        // Ack arriving in the final permitted REQ cycle completes normally.
        $display("[TB] ack on timeout cycle");
        applyStimulus(1, 1, 0, 32'h0000_0500, 32'd0, 1, 1, 5'd6);
        stepClock();
        for (int n = 1; n < TO; n++) stepClock();
        Dmem_ack   = 1'b1;
        Dmem_rdata = 32'h0BAD_F00D;
        sb.push_back('{alu: 32'h500, rdata: 32'h0BAD_F00D, dest: 5'd6, rw: 1'b1, mtr: 1'b1});
        #1;
        checkOutput("lastcyc_req", 32'(Dmem_req), 1);
        checkOutput("lastcyc_stall", 32'(Stall), 0);
        stepClock();
        checkOutput("lastcyc_mem_err", 32'(Mem_err), 0);
        Dmem_ack = 1'b0;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        stepClock();

        // Load that never gets an ack is abandoned after TIMEOUT REQ cycles.
        $display("[TB] load timeout");
        applyStimulus(1, 1, 0, 32'h0000_0300, 32'd0, 1, 1, 5'd7);
        sb.push_back('{alu: 32'h300, rdata: 32'd0, dest: 5'd7, rw: 1'b0, mtr: 1'b1});
        stepClock();
        reqCycles = 0;
        for (int i = 1; i <= 40; i++) begin
            #1;
            if (!Dmem_req) break;
            reqCycles++;
            if (i == 1) checkOutput("timeout_first_stall", 32'(Stall), 1);
            if (i == TO) checkOutput("timeout_last_stall", 32'(Stall), 0);
            stepClock();
        end
        checkOutput("timeout_req_cycles", 32'(reqCycles), TO);
        checkOutput("timeout_mem_err", 32'(Mem_err), 1);
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        stepClock();
        checkOutput("mem_err_sticky", 32'(Mem_err), 1);

        // Reset during the second REQ cycle aborts the access at once.
        $display("[TB] reset during access");
        applyStimulus(1, 1, 0, 32'h0000_0400, 32'd0, 1, 1, 5'd8);
        stepClock();
        stepClock();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(Dmem_req), 0);
        checkOutput("midrst_we", 32'(Dmem_we), 0);
        checkOutput("midrst_stall", 32'(Stall), 0);
        checkOutput("midrst_mem_err", 32'(Mem_err), 0);
        checkOutput("midrst_valid", 32'(valid_out), 0);
        checkOutput("midrst_alu", ALU_result, 0);
        checkOutput("midrst_regwrite", 32'(RegWrite_out), 0);
        checkOutput("midrst_memtoreg", 32'(MemToReg), 0);
        checkOutput("midrst_rdata", MemRead_data, 0);
        checkOutput("midrst_dest", 32'(DestReg_out), 0);
        stepClock();
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        stepClock();
        checkOutput("postrst_idle_req", 32'(Dmem_req), 0);
        applyStimulus(1, 0, 0, 32'h0000_0044, 32'd0, 0, 1, 5'd12);
        sb.push_back('{alu: 32'h44, rdata: 32'd0, dest: 5'd12, rw: 1'b1, mtr: 1'b0});
        stepClock();
        checkOutput("postrst_valid", 32'(valid_out), 1);
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0, 5'd0);
        stepClock();

        checkOutput("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
